// File: rtl/mask_centroid.sv
// rtl/mask_centroid.sv - centre of mass of a thresholded pixel mask, one pixel per clock
module mask_centroid #(
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768,
    parameter int SUM_W    = 32,
    parameter int CNT_W    = 20
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic        valid_in,
    input  logic        tabulate_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        valid_out,
    output logic        busy_out
);

    localparam int STEP_W = $clog2(SUM_W + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SUM_W);

    if (CNT_W < $clog2(H_ACTIVE * V_ACTIVE + 1)) begin : g_cnt_w_check
        $error("CNT_W cannot hold a full frame of pixels");
    end

    typedef enum logic {ACCUM, DIVIDE} state_t;

    state_t             state, state_next;
    logic [SUM_W-1:0]   x_sum, y_sum, x_tot, y_tot;
    logic [CNT_W-1:0]   count, cnt_tot;
    logic [SUM_W-1:0]   x_quo, y_quo, divisor;
    logic [SUM_W:0]     x_rem, y_rem;
    logic [STEP_W-1:0]  step;
    logic               start, done;

    // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
    function automatic logic [2*SUM_W:0] div_step(
        input logic [SUM_W:0]   rem,
        input logic [SUM_W-1:0] quo,
        input logic [SUM_W-1:0] d
    );
        logic [SUM_W:0] trial;
        trial = {rem[SUM_W-1:0], quo[SUM_W-1]};
        if (trial >= {1'b0, d})
            return {trial - {1'b0, d}, quo[SUM_W-2:0], 1'b1};
        else
            return {trial, quo[SUM_W-2:0], 1'b0};
    endfunction

    // Totals include the pixel presented in the current cycle.
    always_comb begin
        x_tot   = x_sum + (valid_in ? SUM_W'(x_in) : '0);
        y_tot   = y_sum + (valid_in ? SUM_W'(y_in) : '0);
        cnt_tot = count + CNT_W'(valid_in);
        start   = (state == ACCUM) && tabulate_in && (cnt_tot != '0);
        done    = (state == DIVIDE) && (step == STEP_LAST);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            state <= ACCUM;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy_out   = 1'b0;
        case (state)
            ACCUM:  if (start) state_next = DIVIDE;
            DIVIDE: begin
                busy_out = 1'b1;
                if (done) state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            x_sum     <= '0;
            y_sum     <= '0;
            count     <= '0;
            x_quo     <= '0;
            y_quo     <= '0;
            x_rem     <= '0;
            y_rem     <= '0;
            divisor   <= '0;
            step      <= '0;
            x_out     <= '0;
            y_out     <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (state == ACCUM) begin
                if (tabulate_in) begin
                    x_sum <= '0;
                    y_sum <= '0;
                    count <= '0;
                    if (start) begin
                        x_quo   <= x_tot;
                        y_quo   <= y_tot;
                        x_rem   <= '0;
                        y_rem   <= '0;
                        divisor <= SUM_W'(cnt_tot);
                        step    <= '0;
                    end
                end else if (valid_in) begin
                    x_sum <= x_tot;
                    y_sum <= y_tot;
                    count <= cnt_tot;
                end
            end else if (done) begin
                x_out     <= x_quo[10:0];
                y_out     <= y_quo[9:0];
                valid_out <= 1'b1;
            end else begin
                {x_rem, x_quo} <= div_step(x_rem, x_quo, divisor);
                {y_rem, y_quo} <= div_step(y_rem, y_quo, divisor);
                step           <= step + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mask_centroid.sv
// tb/tb_mask_centroid.sv - randomized self-checking bench for mask_centroid
module tb_mask_centroid;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic        valid_in;
    logic        tabulate_in;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out;
    logic        busy_out;

    int tests_run    = 0;
    int tests_failed = 0;

    int qx[$];
    int qy[$];

    mask_centroid dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .x_in        (x_in),
        .y_in        (y_in),
        .valid_in    (valid_in),
        .tabulate_in (tabulate_in),
        .x_out       (x_out),
        .y_out       (y_out),
        .valid_out   (valid_out),
        .busy_out    (busy_out)
    );

    always #5 clk_in = ~clk_in;

    // Present one cycle of input; returns 1 ns after the sampling edge.
    task automatic drive(input int x, input int y, input bit v, input bit t);
        x_in        = 11'(x);
        y_in        = 10'(y);
        valid_in    = v;
        tabulate_in = t;
        if (v) begin
            qx.push_back(x);
            qy.push_back(y);
        end
        @(posedge clk_in);
        #1;
        valid_in    = 1'b0;
        tabulate_in = 1'b0;
    endtask

    // Reference: floor of mean coordinate over the pixels of the frame.
    task automatic model_result(output int ex, output int ey);
        longint sx, sy;
        sx = 0;
        sy = 0;
        foreach (qx[i]) begin
            sx += qx[i];
            sy += qy[i];
        end
        ex = (qx.size() > 0) ? int'(sx / qx.size()) : 0;
        ey = (qy.size() > 0) ? int'(sy / qy.size()) : 0;
        qx.delete();
        qy.delete();
    endtask

    // Waits for the result pulse after a tabulate edge; optional noise pixels during DIVIDE.
    task automatic wait_result(input bit noise, output int lat, output int rx, output int ry,
                               output logic after);
        lat   = -1;
        rx    = 0;
        ry    = 0;
        after = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (noise && n <= 20) begin
                x_in        = 11'd1000;
                y_in        = 10'd700;
                valid_in    = 1'b1;
                tabulate_in = (n == 3);
            end else begin
                valid_in    = 1'b0;
                tabulate_in = 1'b0;
            end
            @(posedge clk_in);
            #1;
            if (valid_out) begin
                lat = n;
                rx  = int'(x_out);
                ry  = int'(y_out);
                break;
            end
        end
        valid_in    = 1'b0;
        tabulate_in = 1'b0;
        if (lat > 0) begin
            @(posedge clk_in);
            #1;
            after = valid_out;
        end
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if ({x_out, y_out, valid_out, busy_out} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: x=%0d y=%0d v=%b b=%b, required all 0",
                     x_out, y_out, valid_out, busy_out);
        end
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    task automatic test_single();
        int ex, ey, lat, rx, ry;
        logic after;
        drive(100, 50, 1'b1, 1'b0);
        repeat (3) drive(0, 0, 1'b0, 1'b0);
        drive(0, 0, 1'b0, 1'b1);
        tests_run++;
        if (busy_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_busy: busy_out=%b, required 1", busy_out);
        end
        model_result(ex, ey);
        wait_result(1'b0, lat, rx, ry, after);
        tests_run++;
        if (lat !== 33) begin
            tests_failed++;
            $display("FAIL single_latency: %0d cycles, required 33", lat);
        end
        tests_run++;
        if (rx !== ex || ry !== ey) begin
            tests_failed++;
            $display("FAIL single_xy: (%0d,%0d), required (%0d,%0d)", rx, ry, ex, ey);
        end
        tests_run++;
        if (after !== 1'b0 || busy_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_pulse_end: valid=%b busy=%b, required 0 0", after, busy_out);
        end
    endtask

    task automatic test_empty();
        int vseen, bseen;
        vseen = 0;
        bseen = 0;
        drive(0, 0, 1'b0, 1'b1);
        for (int n = 0; n < 40; n++) begin
            if (valid_out) vseen++;
            if (busy_out) bseen++;
            @(posedge clk_in);
            #1;
        end
        tests_run++;
        if (vseen != 0 || bseen != 0) begin
            tests_failed++;
            $display("FAIL empty_activity: valid %0d busy %0d cycles, required 0 0", vseen, bseen);
        end
        tests_run++;
        if (x_out !== 11'd100 || y_out !== 10'd50) begin
            tests_failed++;
            $display("FAIL empty_hold: (%0d,%0d), required (100,50)", x_out, y_out);
        end
    endtask

    task automatic test_four_pixels();
        int ex, ey, lat, rx, ry;
        logic after;
        drive(10, 10, 1'b1, 1'b0);
        drive(20, 10, 1'b1, 1'b0);
        drive(0, 0, 1'b0, 1'b0);
        drive(10, 20, 1'b1, 1'b0);
        drive(21, 21, 1'b1, 1'b0);
        drive(0, 0, 1'b0, 1'b1);
        model_result(ex, ey);
        wait_result(1'b0, lat, rx, ry, after);
        tests_run++;
        if (lat !== 33 || rx !== ex || ry !== ey || rx !== 15 || ry !== 15) begin
            tests_failed++;
            $display("FAIL four_pixels: lat=%0d (%0d,%0d), required 33 (%0d,%0d)",
                     lat, rx, ry, ex, ey);
        end
    endtask

    task automatic test_same_cycle();
        int ex, ey, lat, rx, ry;
        logic after;
        drive(40, 30, 1'b1, 1'b1);
        model_result(ex, ey);
        wait_result(1'b0, lat, rx, ry, after);
        tests_run++;
        if (lat !== 33 || rx !== ex || ry !== ey) begin
            tests_failed++;
            $display("FAIL same_cycle: lat=%0d (%0d,%0d), required 33 (%0d,%0d)",
                     lat, rx, ry, ex, ey);
        end
    endtask

    task automatic test_full_raster();
        int ex, ey, lat, rx, ry;
        logic after;
        for (int y = 0; y < 96; y++)
            for (int x = 0; x < 128; x++)
                drive(x, y, 1'b1, (x == 127) && (y == 95));
        model_result(ex, ey);
        wait_result(1'b0, lat, rx, ry, after);
        tests_run++;
        if (lat !== 33 || rx !== ex || ry !== ey) begin
            tests_failed++;
            $display("FAIL full_raster: lat=%0d (%0d,%0d), required 33 (%0d,%0d)",
                     lat, rx, ry, ex, ey);
        end
        drive(0, 0, 1'b1, 1'b0);
        drive(1023, 767, 1'b1, 1'b1);
        model_result(ex, ey);
        wait_result(1'b0, lat, rx, ry, after);
        tests_run++;
        if (lat !== 33 || rx !== ex || ry !== ey || rx !== 511 || ry !== 383) begin
            tests_failed++;
            $display("FAIL corner_extremes: lat=%0d (%0d,%0d), required 33 (511,383)",
                     lat, rx, ry);
        end
    endtask

    task automatic test_dropped();
        int ex, ey, lat, rx, ry;
        logic after;
        drive(500, 400, 1'b1, 1'b1);
        model_result(ex, ey);
        wait_result(1'b1, lat, rx, ry, after);
        tests_run++;
        if (lat !== 33 || rx !== ex || ry !== ey) begin
            tests_failed++;
            $display("FAIL dropped_current: lat=%0d (%0d,%0d), required 33 (%0d,%0d)",
                     lat, rx, ry, ex, ey);
        end
        repeat (2) drive(0, 0, 1'b0, 1'b0);
        drive(10, 20, 1'b1, 1'b1);
        model_result(ex, ey);
        wait_result(1'b0, lat, rx, ry, after);
        tests_run++;
        if (lat !== 33 || rx !== ex || ry !== ey) begin
            tests_failed++;
            $display("FAIL dropped_next: lat=%0d (%0d,%0d), required 33 (%0d,%0d)",
                     lat, rx, ry, ex, ey);
        end
    endtask

    task automatic test_reset_mid_divide();
        int vseen, ex, ey, lat, rx, ry;
        logic after;
        vseen = 0;
        drive(300, 200, 1'b1, 1'b1);
        qx.delete();
        qy.delete();
        repeat (4) begin
            @(posedge clk_in);
            #1;
            if (valid_out) vseen++;
        end
        rst_in = 1'b1;
        #2;
        tests_run++;
        if (x_out !== 11'd0 || y_out !== 10'd0 || busy_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_abort_state: (%0d,%0d) busy=%b, required (0,0) 0",
                     x_out, y_out, busy_out);
        end
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk_in);
            #1;
            if (valid_out) vseen++;
        end
        tests_run++;
        if (vseen != 0) begin
            tests_failed++;
            $display("FAIL reset_abort_pulse: valid_out seen %0d cycles, required 0", vseen);
        end
        drive(7, 9, 1'b1, 1'b0);
        drive(0, 0, 1'b0, 1'b1);
        model_result(ex, ey);
        wait_result(1'b0, lat, rx, ry, after);
        tests_run++;
        if (lat !== 33 || rx !== ex || ry !== ey) begin
            tests_failed++;
            $display("FAIL reset_recover: lat=%0d (%0d,%0d), required 33 (%0d,%0d)",
                     lat, rx, ry, ex, ey);
        end
    endtask

    task automatic test_random_frames();
        int ex, ey, lat, rx, ry, len;
        logic after;
        for (int f = 0; f < 8; f++) begin
            len = $urandom_range(1, 300);
            for (int c = 0; c < len; c++)
                drive($urandom_range(0, 1023), $urandom_range(0, 767),
                      (c == 0) || ($urandom_range(0, 3) == 0), c == len - 1);
            model_result(ex, ey);
            wait_result(1'b0, lat, rx, ry, after);
            tests_run++;
            if (lat !== 33 || rx !== ex || ry !== ey || after !== 1'b0) begin
                tests_failed++;
                $display("FAIL random_frame_%0d: lat=%0d (%0d,%0d) next_valid=%b, required 33 (%0d,%0d) 0",
                         f, lat, rx, ry, after, ex, ey);
            end
            repeat ($urandom_range(0, 5)) drive(0, 0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst_in      = 1'b1;
        x_in        = '0;
        y_in        = '0;
        valid_in    = 1'b0;
        tabulate_in = 1'b0;
        test_reset();
        test_single();
        test_empty();
        test_four_pixels();
        test_same_cycle();
        test_full_raster();
        test_dropped();
        test_reset_mid_divide();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mask_centroid.md
Name: mask_centroid

Overview:
- Computes the centre of mass of the thresholded mask over one video frame, one pixel per clock.
- Accumulates the x/y coordinate sums and the count of set pixels during the frame.
- On the end-of-frame strobe, divides each sum by the count with a sequential divider.
- Sits between the threshold stage and the crosshair generator; its outputs drive the crosshair position that feeds the VGA mux crosshair input.

Parameters:
- H_ACTIVE, 1024, active pixels per line; x_in never exceeds H_ACTIVE-1.
- V_ACTIVE, 768, active lines per frame; y_in never exceeds V_ACTIVE-1.
- SUM_W, 32, width of the sum accumulators and of the divider datapath.
- CNT_W, 20, width of the pixel counter; must hold H_ACTIVE*V_ACTIVE.

Ports:
- clk_in, input, 1, system pixel clock.
- rst_in, input, 1, asynchronous active-high reset.
- x_in, input, 11, horizontal coordinate of the current pixel.
- y_in, input, 10, vertical coordinate of the current pixel.
- valid_in, input, 1, current pixel is set in the threshold mask.
- tabulate_in, input, 1, single-cycle end-of-frame strobe.
- x_out, output, 11, centroid x, registered.
- y_out, output, 10, centroid y, registered.
- valid_out, output, 1, single-cycle pulse when x_out/y_out update.
- busy_out, output, 1, high while state is DIVIDE.

Behaviour:
- Interface: one clock, clk_in. rst_in is asynchronous and active-high.
- Reset values: state=ACCUM; x_sum, y_sum and count = 0; x_out=0, y_out=0, valid_out=0, busy_out=0.
- State ACCUM:
  - On each clock edge with valid_in=1: x_sum += x_in, y_sum += y_in, count += 1.
  - Sum and count arithmetic is unsigned and zero-extended.
  - Overflow cannot occur with the default parameters; no saturation logic.
- tabulate_in in ACCUM, count (including the current cycle's pixel) > 0:
  - Latch dividends x_sum and y_sum and divisor count, all including any pixel with valid_in=1 in the same cycle.
  - Clear the accumulators and go to DIVIDE.
- tabulate_in in ACCUM, count == 0 after including the current cycle:
  - No division, no valid_out.
  - x_out/y_out hold their previous values; accumulators stay cleared; remain in ACCUM.
- State DIVIDE:
  - Two restoring shift-subtract dividers run in parallel, one quotient bit per cycle, SUM_W cycles in total.
  - valid_in and tabulate_in are ignored; pixels arriving during DIVIDE are dropped and are not counted toward the next frame.
  - busy_out=1.
- Timing: if tabulate_in is sampled at edge k, DIVIDE occupies edges k+1..k+SUM_W. At edge k+SUM_W+1:
  - x_out/y_out load the low 11/10 bits of the quotients;
  - valid_out=1 for exactly that one cycle;
  - state returns to ACCUM, with accumulation active from that edge.
- Quotients are floored (truncating). The remainder is discarded.
- Outputs hold between updates. valid_out is never high for two consecutive cycles.
- rst_in mid-DIVIDE aborts the division: no valid_out, outputs return to 0.
- Default-parameter assumption: the frame blanking interval is longer than SUM_W+1 cycles, so no active pixels arrive while the block is in DIVIDE.

Test Plan:
- Single pixel: valid_in only at (100,50), then tabulate_in -> valid_out exactly 33 cycles after the tabulate edge; x_out=100, y_out=50.
- Four pixels (10,10), (20,10), (10,20), (21,21) -> sums 61/61, count 4; x_out=15, y_out=15 (floor).
- Full frame: valid_in=1 for all 1024x768 pixels -> x_out=511, y_out=383, count latched as 786432.
- Empty frame: tabulate_in with no set pixels after a prior result of (100,50) -> no valid_out, busy_out stays 0, outputs remain (100,50).
- Same-cycle event: valid_in at (40,30) with tabulate_in in the same cycle as the only pixel -> x_out=40, y_out=30.
- Dropped pixel: valid_in at (1000,700) during DIVIDE -> that pixel does not affect the next frame's result.
- Reset mid-DIVIDE: assert rst_in 5 cycles after tabulate -> valid_out never pulses; x_out=0, y_out=0; the next frame computes normally.
